// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcode encodings and flag bit positions for alu_pipe
package alu_pipe_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_SUB        = 3'b000;
  localparam logic [OPW-1:0] OP_NAND       = 3'b001;
  localparam logic [OPW-1:0] OP_LEAD_ONES  = 3'b010;
  localparam logic [OPW-1:0] OP_ONEHOT_DEC = 3'b011;
  localparam logic [OPW-1:0] OP_ADD        = 3'b100;
  localparam logic [OPW-1:0] OP_SSUB       = 3'b101;

  localparam int FLAG_ERR      = 0;
  localparam int FLAG_NEG      = 1;
  localparam int FLAG_POS      = 2;
  localparam int FLAG_OVERFLOW = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational ALU datapath producing result and ERR/NEG/POS/OVERFLOW flags
module alu_pipe_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]              i_a,
  input  logic [WIDTH-1:0]              i_b,
  input  logic [alu_pipe_pkg::OPW-1:0]  i_oper,
  output logic [WIDTH-1:0]              o_result,
  output logic [3:0]                    o_flag
);
  import alu_pipe_pkg::*;

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] diff, sum, lead_cnt, oh_idx, res;
  logic             sub_ovf, add_ovf, lead_run, is_onehot, err, ovf;

  always_comb begin
    diff    = i_a - i_b;
    sum     = i_a + i_b;
    sub_ovf = (i_a[MSB] ^ i_b[MSB]) & (diff[MSB] ^ i_a[MSB]);
    add_ovf = ~(i_a[MSB] ^ i_b[MSB]) & (sum[MSB] ^ i_a[MSB]);

    // Run stays high only while every bit from the MSB down has been 1.
    lead_cnt = '0;
    lead_run = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      lead_run = lead_run & i_a[i];
      lead_cnt = lead_cnt + WIDTH'(lead_run);
    end

    is_onehot = (i_a != '0) && ((i_a & (i_a - ONE)) == '0);
    oh_idx    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_a[i]) oh_idx = WIDTH'(i);
    end

    res = '0;
    err = 1'b0;
    ovf = 1'b0;
    case (i_oper)
      OP_SUB: begin
        res = diff;
        ovf = sub_ovf;
      end
      OP_NAND:      res = ~(i_a & i_b);
      OP_LEAD_ONES: res = lead_cnt;
      OP_ONEHOT_DEC: begin
        if (is_onehot) res = oh_idx;
        else           err = 1'b1;
      end
      OP_ADD: begin
        res = sum;
        ovf = add_ovf;
      end
      OP_SSUB: begin
        if (sub_ovf) begin
          res = i_a[MSB] ? MIN_NEG : MAX_POS;
          ovf = 1'b1;
        end else begin
          res = diff;
        end
      end
      default: err = 1'b1;
    endcase

    o_flag = '0;
    if (err) begin
      o_result         = '0;
      o_flag[FLAG_ERR] = 1'b1;
    end else begin
      o_result              = res;
      o_flag[FLAG_NEG]      = res[MSB];
      o_flag[FLAG_POS]      = !res[MSB] && (res != '0);
      o_flag[FLAG_OVERFLOW] = ovf;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with saturating delivered-error counter
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [OPW-1:0]   i_oper,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_clr_err,
  output logic [CNT_W-1:0] o_err_cnt
);
  import alu_pipe_pkg::*;

  logic             ready_en_q, ready_en_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [OPW-1:0]   s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_flag_q, out_flag_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flag;
  logic             s1_advance, in_fire, out_fire;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (s1_a_q),
    .i_b      (s1_b_q),
    .i_oper   (s1_op_q),
    .o_result (core_result),
    .o_flag   (core_flag)
  );

  // ready_en_q keeps o_ready low until the first clock after reset release.
  assign s1_advance = !out_valid_q || i_ready;
  assign o_ready    = ready_en_q && (!s1_valid_q || s1_advance);
  assign in_fire    = i_valid && o_ready;
  assign out_fire   = out_valid_q && i_ready;

  assign o_valid   = out_valid_q;
  assign o_result  = out_result_q;
  assign o_flag    = out_flag_q;
  assign o_err_cnt = err_cnt_q;

  always_comb begin
    ready_en_d   = 1'b1;
    s1_valid_d   = s1_valid_q && !s1_advance;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_op_d      = s1_op_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flag_d   = out_flag_q;
    err_cnt_d    = err_cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = i_arg0;
      s1_b_d     = i_arg1;
      s1_op_d    = i_oper;
    end

    if (s1_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = core_result;
        out_flag_d   = core_flag;
      end
    end

    if (i_clr_err)
      err_cnt_d = '0;
    else if (out_fire && out_flag_q[FLAG_ERR] && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_en_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flag_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      ready_en_q   <= ready_en_d;
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flag_q   <= out_flag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed table-driven bench for alu_pipe at WIDTH=4, CNT_W=2
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] arg0, arg1;
  logic [2:0] oper;
  logic       in_valid, in_ready, clr_err;
  logic       out_ready_dut, out_valid;
  logic [3:0] result, flag;
  logic [1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] flg;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  alu_pipe #(.WIDTH(4), .OPW(3), .CNT_W(2)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_arg0    (arg0),
    .i_arg1    (arg1),
    .i_oper    (oper),
    .i_valid   (in_valid),
    .o_ready   (out_ready_dut),
    .o_result  (result),
    .o_flag    (flag),
    .o_valid   (out_valid),
    .i_ready   (in_ready),
    .i_clr_err (clr_err),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    in_valid = 1'b1;
    oper     = vecs[idx].op;
    arg0     = vecs[idx].a;
    arg1     = vecs[idx].b;
  endtask

  task automatic run_single(input int idx);
    @(negedge clk);
    drive(idx);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("v%0d early_valid", idx), 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d valid", idx), 32'(out_valid), 32'd1);
    check($sformatf("v%0d result", idx), 32'(result), 32'(vecs[idx].res));
    check($sformatf("v%0d flag", idx), 32'(flag), 32'(vecs[idx].flg));
  endtask

  task automatic send_reserved();
    @(negedge clk);
    in_valid = 1'b1;
    oper     = 3'b110;
    arg0     = 4'h3;
    arg1     = 4'h1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    // op, a, b, result, flags {OVF,POS,NEG,ERR}
    vecs[0]  = '{3'b000, 4'b0101, 4'b0011, 4'b0010, 4'b0100};
    vecs[1]  = '{3'b100, 4'b0111, 4'b0001, 4'b1000, 4'b1010};
    vecs[2]  = '{3'b001, 4'b1111, 4'b0000, 4'b1111, 4'b0010};
    vecs[3]  = '{3'b010, 4'b1100, 4'b0000, 4'b0010, 4'b0100};
    vecs[4]  = '{3'b010, 4'b1111, 4'b0000, 4'b0100, 4'b0100};
    vecs[5]  = '{3'b011, 4'b0010, 4'b0000, 4'b0001, 4'b0100};
    vecs[6]  = '{3'b011, 4'b0110, 4'b0000, 4'b0000, 4'b0001};
    vecs[7]  = '{3'b101, 4'b0111, 4'b1000, 4'b0111, 4'b1100};
    vecs[8]  = '{3'b101, 4'b1000, 4'b0001, 4'b1000, 4'b1010};
    vecs[9]  = '{3'b011, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[10] = '{3'b110, 4'b0101, 4'b0011, 4'b0000, 4'b0001};
    vecs[11] = '{3'b111, 4'b0101, 4'b0011, 4'b0000, 4'b0001};
    vecs[12] = '{3'b000, 4'b0011, 4'b0101, 4'b1110, 4'b0010};
    vecs[13] = '{3'b000, 4'b1000, 4'b0001, 4'b0111, 4'b1100};
    vecs[14] = '{3'b001, 4'b1010, 4'b0110, 4'b1101, 4'b0010};
    vecs[15] = '{3'b010, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
    vecs[16] = '{3'b011, 4'b1000, 4'b0000, 4'b0011, 4'b0100};
    vecs[17] = '{3'b000, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
    vecs[18] = '{3'b101, 4'b0011, 4'b0010, 4'b0001, 4'b0100};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    clr_err  = 1'b0;
    arg0     = '0;
    arg1     = '0;
    oper     = '0;

    repeat (3) @(negedge clk);
    check("rst o_valid", 32'(out_valid), 32'd0);
    check("rst o_result", 32'(result), 32'd0);
    check("rst o_flag", 32'(flag), 32'd0);
    check("rst o_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst o_ready", 32'(out_ready_dut), 32'd1);

    for (int i = 0; i < NV; i++) run_single(i);

    // Back-to-back SUB, ADD, NAND: results on consecutive cycles
    @(negedge clk);
    drive(0);
    @(posedge clk);
    @(negedge clk);
    check("b2b +1 valid", 32'(out_valid), 32'd0);
    drive(1);
    @(posedge clk);
    @(negedge clk);
    check("b2b +2 valid", 32'(out_valid), 32'd1);
    check("b2b +2 result", 32'(result), 32'(vecs[0].res));
    check("b2b +2 flag", 32'(flag), 32'(vecs[0].flg));
    drive(2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b +3 valid", 32'(out_valid), 32'd1);
    check("b2b +3 result", 32'(result), 32'(vecs[1].res));
    check("b2b +3 flag", 32'(flag), 32'(vecs[1].flg));
    @(posedge clk);
    @(negedge clk);
    check("b2b +4 valid", 32'(out_valid), 32'd1);
    check("b2b +4 result", 32'(result), 32'(vecs[2].res));
    check("b2b +4 flag", 32'(flag), 32'(vecs[2].flg));
    @(posedge clk);
    @(negedge clk);
    check("b2b +5 valid", 32'(out_valid), 32'd0);

    // Backpressure: 5 ops, i_ready low for the first cycles then random
    begin
      int sent = 0;
      int got = 0;
      logic prev_stall = 1'b0;
      logic [3:0] prev_res = '0;
      logic [3:0] prev_flg = '0;
      for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
        @(negedge clk);
        in_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
        if (sent < 5) drive(sent);
        else in_valid = 1'b0;
        #1;
        if (prev_stall) begin
          check("bp stall valid", 32'(out_valid), 32'd1);
          check("bp stall result", 32'(result), 32'(prev_res));
          check("bp stall flag", 32'(flag), 32'(prev_flg));
        end
        if ((sent - got) == 2 && !in_ready)
          check("bp full o_ready", 32'(out_ready_dut), 32'd0);
        if (out_valid && in_ready) begin
          check($sformatf("bp out%0d result", got), 32'(result), 32'(vecs[got].res));
          check($sformatf("bp out%0d flag", got), 32'(flag), 32'(vecs[got].flg));
          got++;
        end
        if (in_valid && out_ready_dut) sent++;
        prev_stall = out_valid && !in_ready;
        prev_res   = result;
        prev_flg   = flag;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_ready = 1'b1;
      check("bp delivered count", 32'(got), 32'd5);
      @(posedge clk);
      @(negedge clk);
      check("bp drained valid", 32'(out_valid), 32'd0);
    end

    // Error counter saturation and clear priority
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    check("cnt cleared", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      send_reserved();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cnt after err %0d", k + 1), 32'(err_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    @(negedge clk);
    in_valid = 1'b1;
    oper     = 3'b111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("clr coincide valid", 32'(out_valid), 32'd1);
    check("clr coincide err flag", 32'(flag[0]), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    check("clr priority cnt", 32'(err_cnt), 32'd0);

    // Reset with two ops in flight
    @(negedge clk);
    oper     = 3'b110;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst o_valid", 32'(out_valid), 32'd0);
    check("midrst o_flag", 32'(flag), 32'd0);
    check("midrst o_err_cnt", 32'(err_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("midrst no stale %0d", k), 32'(out_valid), 32'd0);
    end
    check("midrst cnt after", 32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
